processor_stage2: RTL and testbench

PROCESSOR_STAGE2 -- requirements
Module: processor_stage2

---
 rtl/processor_pkg.sv | 54 +++++
 rtl/processor_operand_select.sv | 58 +++++
 rtl/processor_stage2.sv | 161 ++++++++++++++++
 tb/tb_processor_stage2.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// processor_pkg -- definitions shared by the pipeline stages.
//
// Holds the instruction field positions, the opcode constants (OP_*), the
// ALU function codes (ALU_OP_*, carried in imm8[2:0] of OP_ALU and decoded
// in stage3), the stage2 state encoding and two helpers that say which
// source registers an opcode actually reads.
//
// Instruction layout (18 bits): op[17:14] rx[13:11] ry[10:8] imm8[7:0].
package processor_pkg;

  localparam int OP_MSB  = 17;
  localparam int OP_LSB  = 14;
  localparam int RX_MSB  = 13;
  localparam int RX_LSB  = 11;
  localparam int RY_MSB  = 10;
  localparam int RY_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP              = 4'h0;
  localparam logic [3:0] OP_ALU              = 4'h1;  // rx <= rx (ALU_OP) ry
  localparam logic [3:0] OP_LOAD_IMMEDIATE   = 4'h2;  // rx <= sext(imm8)
  localparam logic [3:0] OP_LOAD_FROM_MEMORY = 4'h3;  // rx <= mem[ry + imm8]
  localparam logic [3:0] OP_WRITE_TO_MEMORY  = 4'h4;  // mem[ry + imm8] <= rx
  localparam logic [3:0] OP_BRANCH_ZERO      = 4'h5;  // if rx == 0 : ip += imm8
  localparam logic [3:0] OP_JUMP             = 4'h6;  // ip <= ry + imm8
  localparam logic [3:0] OP_WAIT             = 4'h7;  // stall imm8 cycles

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_AND = 3'd2;
  localparam logic [2:0] ALU_OP_OR  = 3'd3;
  localparam logic [2:0] ALU_OP_XOR = 3'd4;
  localparam logic [2:0] ALU_OP_SHL = 3'd5;
  localparam logic [2:0] ALU_OP_SHR = 3'd6;
  localparam logic [2:0] ALU_OP_MOV = 3'd7;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZARD = 2'd1,
    ST_WAIT   = 2'd2
  } stage2_state_t;

  // rx is a source only where it is read; for loads it is the destination.
  function automatic logic uses_rx(input logic [3:0] op);
    return (op == OP_ALU) || (op == OP_WRITE_TO_MEMORY) || (op == OP_BRANCH_ZERO);
  endfunction

  function automatic logic uses_ry(input logic [3:0] op);
    return (op == OP_ALU) || (op == OP_LOAD_FROM_MEMORY) ||
           (op == OP_WRITE_TO_MEMORY) || (op == OP_JUMP);
  endfunction

endpackage

// File: rtl/processor_operand_select.sv
// processor_operand_select -- operand sourcing and read-after-write hazard.
//
// Build option: STAGE2_FORWARD_EN
//   defined   : a write-back to a source register this cycle is bypassed
//               straight into op0/op1; hazard is never raised.
//   undefined : op0/op1 come from the register file; hazard is raised when a
//               valid word reads a register that is being written back now.
//
// Ports
//   in_valid                         stage1 word valid
//   op, rx, ry                       decoded fields of the incoming word
//   reg_read_data0/1                 register file data for rx/ry
//   wb_enable, wb_addr, wb_data      stage3 write-back
//   op0, op1                         selected operands
//   hazard                           hold the word for one cycle
module processor_operand_select
  import processor_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic                 in_valid,
  input  logic [3:0]           op,
  input  logic [2:0]           rx,
  input  logic [2:0]           ry,
  input  logic [WORD_SIZE-1:0] reg_read_data0,
  input  logic [WORD_SIZE-1:0] reg_read_data1,
  input  logic                 wb_enable,
  input  logic [2:0]           wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic [WORD_SIZE-1:0] op0,
  output logic [WORD_SIZE-1:0] op1,
  output logic                 hazard
);

`ifdef STAGE2_FORWARD_EN
  // Forwarding is independent of opcode; an unused operand is harmless.
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{in_valid, op};

  always_comb begin
    op0    = (wb_enable && (wb_addr == rx)) ? wb_data : reg_read_data0;
    op1    = (wb_enable && (wb_addr == ry)) ? wb_data : reg_read_data1;
    hazard = 1'b0;
  end
`else
  // Write-back data only matters when it is bypassed.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;

  always_comb begin
    op0    = reg_read_data0;
    op1    = reg_read_data1;
    hazard = in_valid && wb_enable &&
             ((uses_rx(op) && (wb_addr == rx)) || (uses_ry(op) && (wb_addr == ry)));
  end
`endif

endmodule

// File: rtl/processor_stage2.sv
// processor_stage2 -- decode / operand fetch stage.
//
// Decodes the word from stage1, reads rx/ry from the register file, computes
// ry + sext(imm8) (which doubles as the synchronous data-memory address so
// the read data lands during stage3) and presents everything to stage3 one
// cycle after acceptance. Cycles without an accepted word emit a bubble
// (no_operation=1, mem_write_enable=0, other outputs hold).
//
// Handshake with stage1: a word is taken on a rising clock edge when
// in_valid=1, stall=0 and flush=0. While stall=1 stage1 holds in_code_word
// and in_ip unchanged. flush overrides everything: the word is dropped, any
// hazard or WAIT count is abandoned and the FSM returns to RUN.
//
// FSM: RUN (issue), HAZARD (one-cycle interlock, only without forwarding),
// WAIT (OP_WAIT countdown of imm8 stalled cycles).
//
// Build option: STAGE2_FORWARD_EN enables write-back bypass (see
// processor_operand_select).
//
// Ports
//   clock, reset                 clock, asynchronous active-low reset
//   in_valid, in_code_word, in_ip   word from stage1
//   stall                        stage1 must hold its outputs
//   flush                        stage3 redirect
//   reg_read_addr0/1, reg_read_data0/1   register file read
//   wb_enable, wb_addr, wb_data  stage3 write-back
//   no_operation ... ip_plus_one registered stage3 operands
//   mem_addr, mem_write_enable, mem_write_data   data memory
module processor_stage2
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_code_word,
  input  logic [ADDR_SIZE-1:0] in_ip,
  output logic                 stall,
  input  logic                 flush,
  output logic [2:0]           reg_read_addr0,
  output logic [2:0]           reg_read_addr1,
  input  logic [WORD_SIZE-1:0] reg_read_data0,
  input  logic [WORD_SIZE-1:0] reg_read_data1,
  input  logic                 wb_enable,
  input  logic [2:0]           wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 no_operation,
  output logic [WORD_SIZE-1:0] alu_data0,
  output logic [WORD_SIZE-1:0] alu_data1,
  output logic [WORD_SIZE-1:0] data1_plus_imm8,
  output logic [WORD_SIZE-1:0] code_word,
  output logic [ADDR_SIZE-1:0] ip,
  output logic [ADDR_SIZE-1:0] ip_plus_one,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_write_enable,
  output logic [WORD_SIZE-1:0] mem_write_data
);

  stage2_state_t        state;
  logic [7:0]           counter;

  logic [3:0]           op;
  logic [2:0]           rx;
  logic [2:0]           ry;
  logic [7:0]           imm8;
  logic [WORD_SIZE-1:0] imm_ext;
  logic [WORD_SIZE-1:0] op0;
  logic [WORD_SIZE-1:0] op1;
  logic [WORD_SIZE-1:0] sum;
  logic                 hazard;
  logic                 accept;

  assign op   = in_code_word[OP_MSB:OP_LSB];
  assign rx   = in_code_word[RX_MSB:RX_LSB];
  assign ry   = in_code_word[RY_MSB:RY_LSB];
  assign imm8 = in_code_word[IMM_MSB:IMM_LSB];

  assign reg_read_addr0 = rx;
  assign reg_read_addr1 = ry;

  processor_operand_select #(
    .WORD_SIZE(WORD_SIZE)
  ) u_operand_select (
    .in_valid      (in_valid),
    .op            (op),
    .rx            (rx),
    .ry            (ry),
    .reg_read_data0(reg_read_data0),
    .reg_read_data1(reg_read_data1),
    .wb_enable     (wb_enable),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .op0           (op0),
    .op1           (op1),
    .hazard        (hazard)
  );

  assign imm_ext = {{(WORD_SIZE-8){imm8[7]}}, imm8};
  assign sum     = op1 + imm_ext;

  // Held low during reset so stage1 never sees a stall from a live hazard.
  // In HAZARD the held word is taken regardless of hazard.
  assign stall  = reset && ((state == ST_WAIT) || ((state == ST_RUN) && hazard));
  assign accept = in_valid && !stall && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= ST_RUN;
      counter          <= 8'd0;
      no_operation     <= 1'b1;
      alu_data0        <= '0;
      alu_data1        <= '0;
      data1_plus_imm8  <= '0;
      code_word        <= '0;
      ip               <= '0;
      ip_plus_one      <= '0;
      mem_addr         <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
    end else if (flush) begin
      state            <= ST_RUN;
      counter          <= 8'd0;
      no_operation     <= 1'b1;
      mem_write_enable <= 1'b0;
    end else begin
      case (state)
        ST_RUN:    if (in_valid && hazard) state <= ST_HAZARD;
        ST_HAZARD: state <= ST_RUN;
        ST_WAIT: begin
          counter <= counter - 8'd1;
          if (counter <= 8'd1) state <= ST_RUN;
        end
        default:   state <= ST_RUN;
      endcase

      if (accept) begin
        no_operation     <= 1'b0;
        alu_data0        <= op0;
        alu_data1        <= op1;
        data1_plus_imm8  <= sum;
        code_word        <= in_code_word;
        ip               <= in_ip;
        ip_plus_one      <= in_ip + ADDR_SIZE'(1);
        mem_addr         <= sum[ADDR_SIZE-1:0];
        mem_write_enable <= (op == OP_WRITE_TO_MEMORY);
        mem_write_data   <= op0;
        // WAIT issues normally; a zero count costs no cycles.
        if (op == OP_WAIT) begin
          counter <= imm8;
          if (imm8 != 8'd0) state <= ST_WAIT;
        end
      end else begin
        no_operation     <= 1'b1;
        mem_write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_processor_stage2.sv
// tb_processor_stage2 -- self-checking bench for processor_stage2.
// A behavioural register file sits on reg_read_*/wb_*; expected stage3
// records are queued when a word is expected to be accepted and compared
// when the DUT presents a non-bubble.
module tb_processor_stage2;
  import processor_pkg::*;

  localparam int AW = 18;
  localparam int WW = 18;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          in_valid;
  logic [WW-1:0] in_code_word;
  logic [AW-1:0] in_ip;
  logic          stall;
  logic          flush;
  logic [2:0]    reg_read_addr0, reg_read_addr1;
  logic [WW-1:0] reg_read_data0, reg_read_data1;
  logic          wb_enable;
  logic [2:0]    wb_addr;
  logic [WW-1:0] wb_data;
  logic          no_operation;
  logic [WW-1:0] alu_data0, alu_data1, data1_plus_imm8, code_word;
  logic [AW-1:0] ip, ip_plus_one, mem_addr;
  logic          mem_write_enable;
  logic [WW-1:0] mem_write_data;

  processor_stage2 #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_code_word    (in_code_word),
    .in_ip           (in_ip),
    .stall           (stall),
    .flush           (flush),
    .reg_read_addr0  (reg_read_addr0),
    .reg_read_addr1  (reg_read_addr1),
    .reg_read_data0  (reg_read_data0),
    .reg_read_data1  (reg_read_data1),
    .wb_enable       (wb_enable),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .no_operation    (no_operation),
    .alu_data0       (alu_data0),
    .alu_data1       (alu_data1),
    .data1_plus_imm8 (data1_plus_imm8),
    .code_word       (code_word),
    .ip              (ip),
    .ip_plus_one     (ip_plus_one),
    .mem_addr        (mem_addr),
    .mem_write_enable(mem_write_enable),
    .mem_write_data  (mem_write_data)
  );

  // Register file environment: combinational read, write-back on the edge.
  logic [WW-1:0] rf [8];
  always @(posedge clock) if (wb_enable) rf[wb_addr] <= wb_data;
  assign reg_read_data0 = rf[reg_read_addr0];
  assign reg_read_data1 = rf[reg_read_addr1];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [WW-1:0] alu0;
    logic [WW-1:0] alu1;
    logic [WW-1:0] sum;
    logic [WW-1:0] code;
    logic [AW-1:0] ipv;
    logic [AW-1:0] ipp1;
    logic [AW-1:0] maddr;
    logic          mwe;
    logic [WW-1:0] mwd;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [WW-1:0] enc(input logic [3:0] op, input logic [2:0] x,
                                        input logic [2:0] y, input logic [7:0] imm);
    return {op, x, y, imm};
  endfunction

  function automatic logic [WW-1:0] operand(input logic [2:0] a);
`ifdef STAGE2_FORWARD_EN
    if (wb_enable && (wb_addr == a)) return wb_data;
`endif
    return rf[a];
  endfunction

  function automatic exp_t model(input logic [WW-1:0] cw, input logic [AW-1:0] ipv);
    exp_t          e;
    logic [7:0]    imm;
    logic [WW-1:0] sx;
    imm     = cw[7:0];
    sx      = {{(WW-8){imm[7]}}, imm};
    e.alu0  = operand(cw[13:11]);
    e.alu1  = operand(cw[10:8]);
    e.sum   = e.alu1 + sx;
    e.code  = cw;
    e.ipv   = ipv;
    e.ipp1  = ipv + AW'(1);
    e.maddr = e.sum[AW-1:0];
    e.mwe   = (cw[17:14] == OP_WRITE_TO_MEMORY);
    e.mwd   = e.alu0;
    return e;
  endfunction

  task automatic check_output();
    exp_t e;
    if (no_operation == 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual=issue required=bubble (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk("alu_data0", alu_data0, e.alu0);
        chk("alu_data1", alu_data1, e.alu1);
        chk("data1_plus_imm8", data1_plus_imm8, e.sum);
        chk("code_word", code_word, e.code);
        chk("ip", ip, e.ipv);
        chk("ip_plus_one", ip_plus_one, e.ipp1);
        chk("mem_addr", mem_addr, e.maddr);
        chk("mem_write_enable", mem_write_enable, e.mwe);
        if (e.mwe) chk("mem_write_data", mem_write_data, e.mwd);
        last_exp = e;
      end
    end else begin
      chk("bubble_mem_write_enable", mem_write_enable, 1'b0);
      chk("hold_alu_data0", alu_data0, last_exp.alu0);
      chk("hold_code_word", code_word, last_exp.code);
      chk("hold_ip", ip, last_exp.ipv);
      chk("hold_mem_addr", mem_addr, last_exp.maddr);
    end
  endtask

  task automatic check_zero();
    chk("rst_no_operation", no_operation, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_alu_data0", alu_data0, 0);
    chk("rst_alu_data1", alu_data1, 0);
    chk("rst_data1_plus_imm8", data1_plus_imm8, 0);
    chk("rst_code_word", code_word, 0);
    chk("rst_ip", ip, 0);
    chk("rst_ip_plus_one", ip_plus_one, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_write_enable", mem_write_enable, 1'b0);
    chk("rst_mem_write_data", mem_write_data, 0);
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive at negedge, check stall, queue the expectation if the
  // word should be taken, check the registered result just after posedge.
  task automatic cycle(input logic v, input logic [WW-1:0] cw, input logic [AW-1:0] ipv,
                       input logic fl, input logic we, input logic [2:0] wa,
                       input logic [WW-1:0] wd, input logic exp_stall,
                       input logic use_sum, input logic [WW-1:0] hand_sum);
    logic acc;
    exp_t e;
    @(negedge clock);
    in_valid = v; in_code_word = cw; in_ip = ipv; flush = fl;
    wb_enable = we; wb_addr = wa; wb_data = wd;
    #1;
    chk("stall", stall, exp_stall);
    acc = v && !exp_stall && !fl;
    if (acc) begin
      e = model(cw, ipv);
      if (use_sum) begin
        e.sum   = hand_sum;
        e.maddr = hand_sum[AW-1:0];
      end
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    chk("no_operation", no_operation, !acc);
    check_output();
  endtask

  task automatic issue(input logic [WW-1:0] cw, input logic [AW-1:0] ipv);
    cycle(1'b1, cw, ipv, 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic stalled(input logic [WW-1:0] cw, input logic [AW-1:0] ipv);
    cycle(1'b1, cw, ipv, 1'b0, 1'b0, 3'd0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]    op;
    logic [2:0]    x;
    logic [2:0]    y;
    logic [7:0]    imm;
    logic [AW-1:0] ipv;
    logic [WW-1:0] sum;
  } vec_t;

  vec_t vecs[7];
  logic [WW-1:0] rf_init[8];

  localparam logic HZ_STALL =
`ifdef STAGE2_FORWARD_EN
    1'b0;
`else
    1'b1;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] cw;
    logic [3:0]    rop;

    rf_init = '{18'h00000, 18'h00123, 18'h00010, 18'h00005,
                18'h3FFFF, 18'h20000, 18'h1FFFF, 18'h00007};
    // {op, rx, ry, imm8, in_ip, ry + sext(imm8) by hand}
    vecs[0] = '{OP_LOAD_FROM_MEMORY, 3'd1, 3'd2, 8'hFF, 18'h00100, 18'h0000F};
    vecs[1] = '{OP_ALU,              3'd3, 3'd1, 8'h05, 18'h00101, 18'h00128};
    vecs[2] = '{OP_WRITE_TO_MEMORY,  3'd4, 3'd2, 8'h00, 18'h3FFFF, 18'h00010};
    vecs[3] = '{OP_ALU,              3'd5, 3'd6, 8'h01, 18'h00102, 18'h20000};
    vecs[4] = '{OP_LOAD_FROM_MEMORY, 3'd0, 3'd4, 8'h01, 18'h00103, 18'h00000};
    vecs[5] = '{OP_JUMP,             3'd7, 3'd5, 8'h80, 18'h00104, 18'h1FF80};
    vecs[6] = '{OP_LOAD_IMMEDIATE,   3'd2, 3'd0, 8'h7F, 18'h00105, 18'h0007F};

    // Reset phase: preload registers through the write-back port.
    reset = 1'b0; in_valid = 1'b0; in_code_word = '0; in_ip = '0; flush = 1'b0;
    wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
    last_exp = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      wb_enable = 1'b1; wb_addr = 3'(i); wb_data = rf_init[i];
    end
    // Hazard-shaped inputs while in reset must not raise stall.
    @(negedge clock);
    in_valid = 1'b1; in_code_word = enc(OP_ALU, 3'd3, 3'd3, 8'h00);
    wb_enable = 1'b1; wb_addr = 3'd3; wb_data = 18'h00005;
    #1;
    check_zero();
    @(posedge clock);
    #1;
    check_zero();
    @(negedge clock);
    in_valid = 1'b0; wb_enable = 1'b0; in_code_word = '0;
    reset = 1'b1;

    idle();

    // Table: back-to-back issue including store pulse and wraps.
    foreach (vecs[i])
      cycle(1'b1, enc(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].imm), vecs[i].ipv,
            1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b1, vecs[i].sum);
    idle();
    idle();

    // Read-after-write on rx (reg3=5, write-back of 9 in the same cycle).
    cw = enc(OP_ALU, 3'd3, 3'd1, 8'h00);
    cycle(1'b1, cw, 18'h00200, 1'b0, 1'b1, 3'd3, 18'd9, HZ_STALL, 1'b0, '0);
    if (HZ_STALL) issue(cw, 18'h00200);
    chk("raw_alu_data0", alu_data0, 18'd9);

    // Read-after-write on ry of a load.
    cw = enc(OP_LOAD_FROM_MEMORY, 3'd0, 3'd5, 8'h02);
    cycle(1'b1, cw, 18'h00201, 1'b0, 1'b1, 3'd5, 18'h00055, HZ_STALL, 1'b0, '0);
    if (HZ_STALL) issue(cw, 18'h00201);
    chk("raw_mem_addr", mem_addr, 18'h00057);

    // Write-back to a load's destination is not a source: no stall.
    cycle(1'b1, enc(OP_LOAD_FROM_MEMORY, 3'd1, 3'd0, 8'h00), 18'h00202,
          1'b0, 1'b1, 3'd1, 18'h00321, 1'b0, 1'b0, '0);

    // WAIT 3: issues, then three stalled bubble cycles, then resumes.
    issue(enc(OP_WAIT, 3'd0, 3'd0, 8'd3), 18'h00300);
    cw = enc(OP_ALU, 3'd1, 3'd2, 8'h00);
    for (int i = 0; i < 3; i++) stalled(cw, 18'h00301);
    issue(cw, 18'h00301);

    // WAIT 0: no stall at all.
    issue(enc(OP_WAIT, 3'd0, 3'd0, 8'd0), 18'h00302);
    issue(cw, 18'h00303);

    // Flush while WAIT count is 2.
    issue(enc(OP_WAIT, 3'd0, 3'd0, 8'd3), 18'h00400);
    stalled(cw, 18'h00401);
    cycle(1'b1, cw, 18'h00401, 1'b1, 1'b0, 3'd0, '0, 1'b1, 1'b0, '0);
    chk("flush_state_run", 32'(dut.state), 32'(ST_RUN));
    issue(cw, 18'h00402);

    // Flush in RUN drops a valid word.
    cycle(1'b1, cw, 18'h00403, 1'b1, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0);

    // Random mix without write-back.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       rop = OP_ALU;
        1:       rop = OP_LOAD_FROM_MEMORY;
        2:       rop = OP_WRITE_TO_MEMORY;
        default: rop = OP_LOAD_IMMEDIATE;
      endcase
      cw = enc(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)));
      cycle(1'($urandom_range(0, 1)), cw, AW'($urandom_range(0, 18'h3FFFF)),
            1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0, '0);
    end

    // Reset asserted mid-WAIT.
    issue(enc(OP_WAIT, 3'd0, 3'd0, 8'd10), 18'h00500);
    stalled(cw, 18'h00501);
    stalled(cw, 18'h00501);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b1;
    #1;
    check_zero();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    last_exp = '0;
    issue(enc(OP_ALU, 3'd2, 3'd7, 8'h01), 18'h00600);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
